// File: rtl/fifo_write_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one FIFO write port among NUM_REQ sources.
// Each written beat carries {last, source id, payload}; writes throttle on the FIFO fill level.
module fifo_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int WIDTH          = 32,
    parameter int LOG_DEPTH      = 10,
    parameter int ALMOSTFULL_VAL = (2**LOG_DEPTH)/2,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       in_valid,
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]       in_last,
    output logic [NUM_REQ-1:0]       in_ready,
    output logic                     fifo_wrreq,
    output logic [WIDTH+IDW:0]       fifo_data,
    input  logic [LOG_DEPTH:0]       fifo_wrusedw,
    input  logic                     fifo_wrfull,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy,
    output logic [31:0]              pkt_count
);

    localparam int CW = LOG_DEPTH + 2;
    localparam logic [CW-1:0] AF_LIMIT = CW'(ALMOSTFULL_VAL);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    fill_pending;
    logic             room;
    logic             pick_found;
    logic [IDW-1:0]   pick_id;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic [IDW-1:0]   next_ptr;

    // The write registered last cycle is not yet in wrusedw, so it counts against the limit.
    assign fill_pending = {1'b0, fifo_wrusedw} + CW'(fifo_wrreq);
    assign room         = !fifo_wrfull && (fill_pending < AF_LIMIT);

    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!pick_found && in_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state == GRANT) begin
            in_ready[grant_id] = room;
        end
    end

    always_comb begin
        sel_data = in_data[int'(grant_id)*WIDTH +: WIDTH];
        sel_last = in_last[grant_id];
        accept   = (state == GRANT) && in_valid[grant_id] && room;
        next_ptr = (int'(grant_id) == NUM_REQ-1) ? '0 : grant_id + 1'b1;
    end

    // Grant is held until the owner's last beat is taken; only then does the pointer move on.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            fifo_wrreq <= 1'b0;
            fifo_data  <= '0;
            pkt_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fifo_wrreq <= 1'b0;
                    if (room && pick_found) begin
                        grant_id <= pick_id;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    fifo_wrreq <= accept;
                    if (accept) begin
                        fifo_data <= {sel_last, grant_id, sel_data};
                        if (sel_last) begin
                            rr_ptr    <= next_ptr;
                            pkt_count <= pkt_count + 32'd1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
